alarm_zone_annunciator: RTL

//  Consumer side of the 8-zone alarm priority encoder: takes the encoded {valid, intruder_zone}

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/alarm_zone_decoder.sv | 18 +
 rtl/alarm_zone_annunciator.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm zone annunciator and its zone decoder:
// FSM state encodings, zone geometry and the code-to-lamp helper.
package alarm_pkg;

   localparam int ZONE_N      = 8;
   localparam int ZONE_CODE_W = 3;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'b00,
      ST_ARMED    = 2'b01,
      ST_ENTRY    = 2'b10,
      ST_ALARM    = 2'b11
   } alarm_state_e;

   // Code k selects lamp k+1; lamps are numbered 1..ZONE_N.
   function automatic logic [1:ZONE_N] code_to_onehot(input logic [ZONE_CODE_W-1:0] code);
      logic [1:ZONE_N] oh;
      for (int i = 1; i <= ZONE_N; i++) begin
         oh[i] = ((int'(code) + 1) == i);
      end
      return oh;
   endfunction

endpackage

// File: rtl/alarm_zone_decoder.sv
// 3-to-8 one-hot zone decoder with enable. Output is all-zero when en is low.
module alarm_zone_decoder
   import alarm_pkg::*;
(
   input  logic                   en,
   input  logic [ZONE_CODE_W-1:0] code,
   output logic [1:ZONE_N]        onehot
);

   // Gate the decoded lamp pattern with the enable.
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot = code_to_onehot(code);
      end
   end

endmodule

// File: rtl/alarm_zone_annunciator.sv
// Alarm zone annunciator: decodes the {valid, intruder_zone} stream back to
// sticky per-zone lamps, runs the arm / entry-delay / alarm FSM and drives
// the siren.
// Optional feature macro: ALARM_SIREN_TIMEOUT_EN (siren auto-silence and
// automatic return to ARMED after SIREN_CYCLES cycles in ALARM).
//
// Input stream: valid qualifies intruder_zone on the same rising edge. There
// is no ready/backpressure; every valid cycle is consumed, and a cycle with
// valid low carries no zone information.
module alarm_zone_annunciator
   import alarm_pkg::*;
#(
   parameter logic [ZONE_CODE_W-1:0] ENTRY_ZONE   = 3'd7,
   parameter int                     ENTRY_DELAY  = 16,
   parameter int                     DLY_W        = 8,
   parameter int                     CNT_W        = 8,
   parameter int                     SIREN_CYCLES = 64
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   arm,
   input  logic                   disarm,
   input  logic                   ack,
   input  logic                   valid,
   input  logic [ZONE_CODE_W-1:0] intruder_zone,
   output logic [1:ZONE_N]        zone_lamp,
   output logic [ZONE_CODE_W-1:0] first_zone,
   output logic                   first_valid,
   output logic [CNT_W-1:0]       event_count,
   output logic [1:0]             state,
   output logic                   armed,
   output logic                   siren
);

   // Reject parameter sets the counters cannot represent.
   if ((ENTRY_DELAY < 1) || (ENTRY_DELAY > (2**DLY_W - 1)) || (SIREN_CYCLES < 1)) begin : g_param_check
      $error("alarm_zone_annunciator: ENTRY_DELAY or SIREN_CYCLES out of range");
   end

   alarm_state_e         state_q, state_d;
   logic [DLY_W-1:0]     dly_q, dly_d;
`ifdef ALARM_SIREN_TIMEOUT_EN
   localparam int SIR_W = (SIREN_CYCLES > 1) ? $clog2(SIREN_CYCLES) : 1;
   logic [SIR_W-1:0]     sir_q, sir_d;
`endif

   logic [1:ZONE_N]        lamp_q;
   logic [ZONE_CODE_W-1:0] first_zone_q;
   logic                   first_valid_q;
   logic [CNT_W-1:0]       count_q;

   logic                   latch_ok;
   logic [1:ZONE_N]        hit;
   logic [1:ZONE_N]        new_hit;
   logic                   lamp_new;

   // Zones latch only while armed in some form and not being disarmed this edge.
   assign latch_ok = (state_q != ST_DISARMED) && !disarm;

   alarm_zone_decoder u_decoder (
      .en     (valid & latch_ok),
      .code   (intruder_zone),
      .onehot (hit)
   );

   assign new_hit  = hit & ~lamp_q;
   assign lamp_new = |new_hit;

   // State register plus entry-delay (and optional siren) counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_DISARMED;
         dly_q   <= '0;
`ifdef ALARM_SIREN_TIMEOUT_EN
         sir_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
`ifdef ALARM_SIREN_TIMEOUT_EN
         sir_q   <= sir_d;
`endif
      end
   end

   // Next-state logic: disarm beats valid, valid beats arm.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
`ifdef ALARM_SIREN_TIMEOUT_EN
      sir_d   = sir_q;
`endif
      unique case (state_q)
         ST_DISARMED: begin
            if (arm && !disarm) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (disarm) begin
               state_d = ST_DISARMED;
            end else if (valid) begin
               if (intruder_zone == ENTRY_ZONE) begin
                  state_d = ST_ENTRY;
                  dly_d   = DLY_W'(ENTRY_DELAY - 1);
               end else begin
                  state_d = ST_ALARM;
               end
            end
         end
         ST_ENTRY: begin
            if (disarm) begin
               state_d = ST_DISARMED;
            end else if (valid && (intruder_zone != ENTRY_ZONE)) begin
               state_d = ST_ALARM;
            end else if (dly_q == '0) begin
               state_d = ST_ALARM;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         ST_ALARM: begin
            if (disarm) begin
               state_d = ST_DISARMED;
            end
`ifdef ALARM_SIREN_TIMEOUT_EN
            else if (sir_q == '0) begin
               state_d = ST_ARMED;
            end else begin
               sir_d = sir_q - SIR_W'(1);
            end
`endif
         end
         default: state_d = ST_DISARMED;
      endcase
`ifdef ALARM_SIREN_TIMEOUT_EN
      if ((state_d == ST_ALARM) && (state_q != ST_ALARM)) begin
         sir_d = SIR_W'(SIREN_CYCLES - 1);
      end
`endif
   end

   // Output decode of the state register.
   always_comb begin
      state = state_q;
      armed = (state_q != ST_DISARMED);
      siren = (state_q == ST_ALARM);
   end

   // Sticky lamps, first-zone capture and saturating new-lamp counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lamp_q        <= '0;
         first_zone_q  <= '0;
         first_valid_q <= 1'b0;
         count_q       <= '0;
      end else if ((state_q == ST_DISARMED) && ack) begin
         lamp_q        <= '0;
         first_zone_q  <= '0;
         first_valid_q <= 1'b0;
         count_q       <= '0;
      end else if (lamp_new) begin
         lamp_q <= lamp_q | new_hit;
         if (count_q != '1) begin
            count_q <= count_q + CNT_W'(1);
         end
         if (!first_valid_q) begin
            first_zone_q  <= intruder_zone;
            first_valid_q <= 1'b1;
         end
      end
   end

   assign zone_lamp   = lamp_q;
   assign first_zone  = first_zone_q;
   assign first_valid = first_valid_q;
   assign event_count = count_q;

endmodule
